uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte buffer and launch sequencer sitting directly upstream of uart_tx.
//  The processor-side MMIO/debug logic pushes bytes at core rate. This block
//  queues them and hands them one at a time to uart_tx over its
//  i_Tx_DV/i_Tx_Byte/o_Tx_Active/o_Tx_Done handshake.
//  Decouples bursty core writes from the ~10417-clock-per-bit serial line.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >= 2
//  ADDR_W   4  log2(DEPTH); pointer width
// PORTS
//  i_Clock       in   1         system clock; all logic on rising edge
//  i_Reset_n     in   1         asynchronous, active-low reset
//  i_Wr_En       in   1         push request; one byte per cycle
//  i_Wr_Byte     in   8         byte to push
//  o_Full        out  1         count == DEPTH
//  o_Empty       out  1         count == 0
//  o_Count       out  ADDR_W+1  occupancy, 0..DEPTH
//  o_Overflow    out  1         sticky: a push was dropped while full
//  o_Tx_DV       out  1         to uart_tx i_Tx_DV
//  o_Tx_Byte     out  8         to uart_tx i_Tx_Byte
//  i_Tx_Active   in   1         from uart_tx o_Tx_Active
//  i_Tx_Done     in   1         from uart_tx o_Tx_Done (high 2 cycles per byte)
// BEHAVIOUR
//  Reset (async, i_Reset_n=0):
//   - Pointers and count go to 0. o_Empty=1, o_Full=0, o_Overflow=0.
//   - o_Tx_DV=0, o_Tx_Byte=8'h00, FSM=S_IDLE. All outputs are registered.
//  Push:
//   - Accepted when i_Wr_En=1 and count<DEPTH (count before the edge).
//   - Push while full: byte dropped, o_Overflow<=1 (held until reset).
//   - Push and pop in the same cycle, not full: count unchanged, both happen.
//   - Full plus simultaneous pop: push still dropped. No bypass.
//   - Pointers wrap modulo DEPTH. Count is ADDR_W+1 bits, never wraps.
//  Launch FSM:
//   - S_IDLE: move to S_LAUNCH when count!=0, i_Tx_Active=0 and i_Tx_Done=0.
//     On that edge latch head byte into o_Tx_Byte and pop it.
//   - S_LAUNCH: o_Tx_DV=1 and o_Tx_Byte stable. On i_Tx_Active=1 go to
//     S_WAIT_DONE with o_Tx_DV<=0 (normal dwell: 1 cycle).
//   - S_WAIT_DONE: on i_Tx_Done=1 go to S_RELEASE.
//   - S_RELEASE: on i_Tx_Done=0 and i_Tx_Active=0 go to S_IDLE.
//  Throughput and latency:
//   - First byte into empty FIFO: o_Tx_DV rises 2 edges after the push edge.
//   - Back-to-back bytes: the next o_Tx_DV follows the fall of i_Tx_Done
//     after at most 2 cycles.
//   - o_Tx_DV is never high while i_Tx_Active=1, except for the single
//     overlap cycle in which S_LAUNCH sees Active rise.
//  Reset mid-byte:
//   - uart_tx has no reset and finishes its byte. This block restarts in S_IDLE.
//   - S_IDLE guards on Active/Done, so no launch until uart_tx is idle.
//   - The in-flight byte is not re-sent.
// STRUCTURE
//  - uart_pkg:
//    - localparams S_IDLE=2'd0, S_LAUNCH=2'd1, S_WAIT_DONE=2'd2, S_RELEASE=2'd3
//    - UART_BYTE_W=8
//  - Sub-module uart_byte_fifo: dual-pointer sync FIFO with count/full/empty.
//    Read is combinational at head.
//  - Top level: FSM, pop strobe, overflow flag, output registers.
// TESTING
//  - Reset: hold i_Reset_n=0 with random inputs. Outputs stay at reset values
//    and o_Count=0. Deassert: no o_Tx_DV while idle.
//  - Single byte: push 8'hA5 into empty FIFO with a behavioural uart_tx,
//    CLKS_PER_BIT=4. Expect o_Tx_DV 1 cycle, serial 0,1,0,1,0,0,1,0,1,1
//    (LSB first), then o_Empty=1.
//  - Burst: push 8'h00..8'h0F in 16 consecutive cycles. Expect o_Full on the
//    16th. The 17th push (8'hFF) is dropped and o_Overflow=1. The line carries
//    00..0F in order; 8'hFF never appears.
//  - Simultaneous: push on the exact cycle of a pop with count=3. Count stays 3
//    and byte order is preserved.
//  - Wrap: 40 bytes written in bursts of 10 with gaps. All 40 are received in
//    order, pointers wrap twice, and there is no overflow.
//  - Reset mid-byte: assert i_Reset_n=0 during data bit 3, release, then push
//    8'h3C. The first launch waits until i_Tx_Active=0 and i_Tx_Done=0, and
//    8'h3C is sent intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer: byte width and
// launch sequencer state encoding.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Dual-pointer synchronous byte FIFO with registered count/full/empty.
// The head entry is presented combinationally on o_Rd_Byte.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Wr_En,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  input  logic                   i_Rd_En,
  output logic [UART_BYTE_W-1:0] o_Rd_Byte,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Full,
  output logic                   o_Empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [ADDR_W:0]        count_d;
  logic                   push;
  logic                   pop;

  // Full blocks pushes even when a pop happens on the same edge (no bypass).
  assign push      = i_Wr_En && !o_Full;
  assign pop       = i_Rd_En && !o_Empty;
  assign o_Rd_Byte = mem[rd_ptr];

  always_comb begin
    count_d = o_Count;
    if (push && !pop) begin
      count_d = o_Count + (ADDR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = o_Count - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_Count <= '0;
      o_Full  <= 1'b0;
      o_Empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      o_Count <= count_d;
      o_Full  <= (count_d == FULL_COUNT);
      o_Empty <= (count_d == '0);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Wr_Byte;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue plus launch sequencer feeding uart_tx over its
// DV/Byte/Active/Done handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Wr_En,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Overflow,
  output logic                   o_Tx_DV,
  output logic [UART_BYTE_W-1:0] o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done
);

  tx_state_e              state_q;
  tx_state_e              state_d;
  logic                   pop;
  logic [UART_BYTE_W-1:0] head_byte;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Wr_En   (i_Wr_En),
    .i_Wr_Byte (i_Wr_Byte),
    .i_Rd_En   (pop),
    .o_Rd_Byte (head_byte),
    .o_Count   (o_Count),
    .o_Full    (o_Full),
    .o_Empty   (o_Empty)
  );

  // Idle also waits for Active/Done low so a byte still in flight after a
  // reset of this block is never overrun.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!o_Empty && !i_Tx_Active && !i_Tx_Done) begin
          state_d = S_LAUNCH;
          pop     = 1'b1;
        end
      end
      S_LAUNCH:    if (i_Tx_Active)               state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (i_Tx_Done)                 state_d = S_RELEASE;
      S_RELEASE:   if (!i_Tx_Done && !i_Tx_Active) state_d = S_IDLE;
      default:                                     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= S_IDLE;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= '0;
      o_Overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      o_Tx_DV <= (state_d == S_LAUNCH);
      if (pop)                 o_Tx_Byte  <= head_byte;
      if (i_Wr_En && o_Full)   o_Overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo driving a behavioural uart_tx
// (4 clocks per bit) and decoding its serial line.
module tb_uart_tx_fifo;

  localparam int CPB      = 4;
  localparam int M_IDLE   = 0;
  localparam int M_START  = 1;
  localparam int M_DATA   = 2;
  localparam int M_STOP   = 3;
  localparam int M_DONE   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       full, empty, overflow, tx_dv;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       tx_active, tx_done;
  logic       hold_busy = 1'b0;

  int checks = 0;
  int passed = 0;

  // Behavioural uart_tx (no reset, like the real one)
  int       m_st  = M_IDLE;
  int       m_cnt = 0;
  int       m_bit = 0;
  logic [7:0] m_sh = 8'h00;
  logic     m_line;
  logic     m_active;
  int       dv_busy = 0;

  // Serial line decoder
  logic       r_busy = 1'b0;
  int         r_cnt = 0;
  logic [7:0] r_sh = 8'h00;
  int         frame_err = 0;
  logic [7:0] ser_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Wr_En     (wr_en),
    .i_Wr_Byte   (wr_byte),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (count),
    .o_Overflow  (overflow),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done)
  );

  assign m_active  = (m_st == M_START) || (m_st == M_DATA) || (m_st == M_STOP) ||
                     ((m_st == M_IDLE) && tx_dv);
  assign tx_active = m_active || hold_busy;
  assign tx_done   = (m_st == M_DONE);

  always_comb begin
    m_line = 1'b1;
    if (m_st == M_START) m_line = 1'b0;
    else if (m_st == M_DATA) m_line = m_sh[m_bit];
  end

  always @(posedge clk) begin
    case (m_st)
      M_IDLE: if (tx_dv) begin m_sh <= tx_byte; m_cnt <= 0; m_st <= M_START; end
      M_START: begin
        if (m_cnt == CPB-1) begin m_cnt <= 0; m_bit <= 0; m_st <= M_DATA; end
        else m_cnt <= m_cnt + 1;
      end
      M_DATA: begin
        if (m_cnt == CPB-1) begin
          m_cnt <= 0;
          if (m_bit == 7) m_st <= M_STOP;
          else m_bit <= m_bit + 1;
        end else m_cnt <= m_cnt + 1;
      end
      M_STOP: begin
        if (m_cnt == CPB-1) begin m_cnt <= 0; m_st <= M_DONE; end
        else m_cnt <= m_cnt + 1;
      end
      default: begin
        if (m_cnt == 1) begin m_cnt <= 0; m_st <= M_IDLE; end
        else m_cnt <= m_cnt + 1;
      end
    endcase
  end

  always @(posedge clk) begin
    if (tx_dv && (m_st != M_IDLE)) dv_busy <= dv_busy + 1;
  end

  always @(posedge clk) begin
    if (!r_busy) begin
      if (m_line == 1'b0) begin r_busy <= 1'b1; r_cnt <= 1; end
    end else begin
      r_cnt <= r_cnt + 1;
      if (r_cnt >= 6 && r_cnt <= 34 && ((r_cnt - 6) % 4) == 0)
        r_sh[(r_cnt - 6) / 4] <= m_line;
      if (r_cnt == 38) begin
        if (m_line != 1'b1) frame_err <= frame_err + 1;
        ser_q.push_back(r_sh);
        r_busy <= 1'b0;
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 4 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (empty && !tx_dv && m_st == M_IDLE && !r_busy) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 4) $display("FAIL %s_drain: timed out after %0d cycles, empty=%0b", tag, cyc, empty);
    else passed++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en   = 1'($urandom_range(0, 1));
      wr_byte = 8'($urandom_range(0, 255));
      checks += 6;
      if (tx_dv !== 1'b0) $display("FAIL rst_dv: got %b want 0", tx_dv); else passed++;
      if (tx_byte !== 8'h00) $display("FAIL rst_byte: got %h want 00", tx_byte); else passed++;
      if (count !== 5'd0) $display("FAIL rst_count: got %0d want 0", count); else passed++;
      if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else passed++;
      if (full !== 1'b0) $display("FAIL rst_full: got %b want 0", full); else passed++;
      if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else passed++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (tx_dv !== 1'b0) $display("FAIL idle_dv: got %b want 0", tx_dv); else passed++;
    end
  endtask

  task automatic test_single();
    int lat = 0;
    int dv_cycles = 0;
    logic [9:0] bits = '0;
    ser_q.delete();
    @(negedge clk);
    wr_en = 1'b1;
    wr_byte = 8'hA5;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (tx_dv) lat = i;
    end
    checks++;
    if (lat != 2) $display("FAIL single_latency: got %0d want 2", lat); else passed++;
    dv_cycles = tx_dv ? 1 : 0;
    checks++;
    if (tx_byte !== 8'hA5) $display("FAIL single_byte: got %h want a5", tx_byte); else passed++;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (tx_dv) dv_cycles++;
      if ((i % 4) == 2) bits[(i - 2) / 4] = m_line;
    end
    checks += 2;
    if (dv_cycles != 1) $display("FAIL single_dv_width: got %0d want 1", dv_cycles); else passed++;
    if (bits !== 10'b1101001010) $display("FAIL single_serial: got %b want 1101001010", bits); else passed++;
    wait_drain("single");
    checks += 2;
    if (empty !== 1'b1) $display("FAIL single_empty: got %b want 1", empty); else passed++;
    if (ser_q.size() != 1 || ser_q[0] !== 8'hA5)
      $display("FAIL single_rx: got %0d bytes first %h want 1 byte a5", ser_q.size(), ser_q.size() ? ser_q[0] : 8'h00);
    else passed++;
  endtask

  task automatic test_burst();
    int bad = 0;
    ser_q.delete();
    @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        checks += 2;
        if (full !== 1'b0) $display("FAIL burst_full15: got %b want 0", full); else passed++;
        if (count !== 5'd15) $display("FAIL burst_count15: got %0d want 15", count); else passed++;
      end
      wr_en = 1'b1;
      wr_byte = 8'(i);
    end
    @(negedge clk);
    checks += 3;
    if (full !== 1'b1) $display("FAIL burst_full16: got %b want 1", full); else passed++;
    if (count !== 5'd16) $display("FAIL burst_count16: got %0d want 16", count); else passed++;
    if (overflow !== 1'b0) $display("FAIL burst_ovf_early: got %b want 0", overflow); else passed++;
    wr_byte = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    checks += 2;
    if (overflow !== 1'b1) $display("FAIL burst_ovf: got %b want 1", overflow); else passed++;
    if (count !== 5'd16) $display("FAIL burst_count17: got %0d want 16", count); else passed++;
    hold_busy = 1'b0;
    wait_drain("burst");
    checks += 3;
    if (ser_q.size() != 16) $display("FAIL burst_rx_len: got %0d want 16", ser_q.size()); else passed++;
    for (int i = 0; i < ser_q.size() && i < 16; i++) if (ser_q[i] !== 8'(i)) bad++;
    if (bad != 0) $display("FAIL burst_rx_order: got %0d wrong bytes want 0", bad); else passed++;
    if (overflow !== 1'b1) $display("FAIL burst_ovf_sticky: got %b want 1", overflow); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [4];
    int bad = 0;
    exp[0] = 8'h10; exp[1] = 8'h11; exp[2] = 8'h12; exp[3] = 8'h13;
    pulse_reset();
    ser_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_byte = exp[i];
    end
    @(negedge clk);
    checks += 2;
    if (count !== 5'd3) $display("FAIL simul_pre_count: got %0d want 3", count); else passed++;
    if (overflow !== 1'b0) $display("FAIL simul_ovf_cleared: got %b want 0", overflow); else passed++;
    hold_busy = 1'b0;
    wr_byte = exp[3];
    @(negedge clk);
    wr_en = 1'b0;
    checks += 3;
    if (count !== 5'd3) $display("FAIL simul_count: got %0d want 3", count); else passed++;
    if (tx_dv !== 1'b1) $display("FAIL simul_dv: got %b want 1", tx_dv); else passed++;
    if (tx_byte !== 8'h10) $display("FAIL simul_byte: got %h want 10", tx_byte); else passed++;
    wait_drain("simul");
    checks += 2;
    if (ser_q.size() != 4) $display("FAIL simul_rx_len: got %0d want 4", ser_q.size()); else passed++;
    for (int i = 0; i < ser_q.size() && i < 4; i++) if (ser_q[i] !== exp[i]) bad++;
    if (bad != 0) $display("FAIL simul_rx_order: got %0d wrong bytes want 0", bad); else passed++;
  endtask

  task automatic test_wrap();
    int bad = 0;
    ser_q.delete();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        wr_en = 1'b1;
        wr_byte = 8'(8'h40 + b * 10 + j);
      end
      @(negedge clk);
      wr_en = 1'b0;
      repeat (460) @(negedge clk);
    end
    wait_drain("wrap");
    checks += 3;
    if (overflow !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", overflow); else passed++;
    if (ser_q.size() != 40) $display("FAIL wrap_rx_len: got %0d want 40", ser_q.size()); else passed++;
    for (int i = 0; i < ser_q.size() && i < 40; i++) if (ser_q[i] !== 8'(8'h40 + i)) bad++;
    if (bad != 0) $display("FAIL wrap_rx_order: got %0d wrong bytes want 0", bad); else passed++;
  endtask

  task automatic test_reset_mid_byte();
    int cyc = 0;
    ser_q.delete();
    @(negedge clk);
    wr_en = 1'b1;
    wr_byte = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    while (!(m_st == M_DATA && m_bit == 3) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 200) $display("FAIL midrst_reach_bit3: timed out, state %0d", m_st); else passed++;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b1;
    wr_byte = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    checks += 2;
    if (count !== 5'd1) $display("FAIL midrst_count: got %0d want 1", count); else passed++;
    if (tx_dv !== 1'b0) $display("FAIL midrst_no_early_dv: got %b want 0", tx_dv); else passed++;
    cyc = 0;
    while (!tx_dv && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checks += 3;
    if (!tx_dv) $display("FAIL midrst_launch: no o_Tx_DV within %0d cycles", cyc); else passed++;
    if (m_st != M_IDLE || tx_done) $display("FAIL midrst_launch_idle: uart state %0d done %b want 0 0", m_st, tx_done); else passed++;
    if (tx_byte !== 8'h3C) $display("FAIL midrst_byte: got %h want 3c", tx_byte); else passed++;
    wait_drain("midrst");
    checks++;
    if (ser_q.size() != 2 || ser_q[0] !== 8'h5A || ser_q[1] !== 8'h3C)
      $display("FAIL midrst_rx: got %0d bytes %h %h want 2 bytes 5a 3c", ser_q.size(),
               ser_q.size() > 0 ? ser_q[0] : 8'h00, ser_q.size() > 1 ? ser_q[1] : 8'h00);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simultaneous();
    test_wrap();
    test_reset_mid_byte();
    checks += 2;
    if (dv_busy != 0) $display("FAIL dv_while_busy: got %0d cycles want 0", dv_busy); else passed++;
    if (frame_err != 0) $display("FAIL stop_bit: got %0d framing errors want 0", frame_err); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
